// File: rtl/mem_port_arbiter_if.sv
// Bundles the IF requester, LS requester and shared memory port of mem_port_arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters' and memory's view.
interface mem_port_arbiter_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                    if_req_valid;
   logic [ADDR_WIDTH-1:0]   if_addr;
   logic                    if_stall;
   logic                    if_rsp_valid;
   logic [DATA_WIDTH-1:0]   if_rsp_data;

   logic                    ls_req_valid;
   logic [ADDR_WIDTH-1:0]   ls_addr;
   logic                    ls_write;
   logic [DATA_WIDTH-1:0]   ls_wdata;
   logic [DATA_WIDTH/8-1:0] ls_wstrb;
   logic                    ls_stall;
   logic                    ls_rsp_valid;
   logic [DATA_WIDTH-1:0]   ls_rsp_data;

   logic                    mem_req_valid;
   logic [ADDR_WIDTH-1:0]   mem_addr;
   logic                    mem_write;
   logic [DATA_WIDTH-1:0]   mem_wdata;
   logic [DATA_WIDTH/8-1:0] mem_wstrb;
   logic                    mem_stall;
   logic                    mem_rsp_valid;
   logic [DATA_WIDTH-1:0]   mem_rsp_data;

   modport slave (
      input  if_req_valid, if_addr,
      output if_stall, if_rsp_valid, if_rsp_data,
      input  ls_req_valid, ls_addr, ls_write, ls_wdata, ls_wstrb,
      output ls_stall, ls_rsp_valid, ls_rsp_data,
      output mem_req_valid, mem_addr, mem_write, mem_wdata, mem_wstrb,
      input  mem_stall, mem_rsp_valid, mem_rsp_data
   );

   modport master (
      output if_req_valid, if_addr,
      input  if_stall, if_rsp_valid, if_rsp_data,
      output ls_req_valid, ls_addr, ls_write, ls_wdata, ls_wstrb,
      input  ls_stall, ls_rsp_valid, ls_rsp_data,
      input  mem_req_valid, mem_addr, mem_write, mem_wdata, mem_wstrb,
      output mem_stall, mem_rsp_valid, mem_rsp_data
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction in flight.
// LS has priority; a saturating starvation counter forces an IF grant after STARVE_LIMIT LS wins.
module mem_port_arbiter #(
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input logic              clk,
   input logic              reset,
   mem_port_arbiter_if.slave bus
);
   localparam int unsigned STRB_W = DATA_WIDTH / 8;
   localparam int unsigned CNT_W  = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
   typedef enum logic {OWN_IF, OWN_LS} owner_t;

   state_t              state_q, state_d;
   owner_t              owner_q, owner_d;
   logic [CNT_W-1:0]    starve_q, starve_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                write_q, write_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [STRB_W-1:0]   wstrb_q, wstrb_d;

   logic grant_if;
   logic grant_ls;
   logic rsp_fire;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         owner_q  <= OWN_IF;
         starve_q <= '0;
         addr_q   <= '0;
         write_q  <= 1'b0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         starve_q <= starve_d;
         addr_q   <= addr_d;
         write_q  <= write_d;
         wdata_q  <= wdata_d;
         wstrb_q  <= wstrb_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      starve_d = starve_q;
      addr_d   = addr_q;
      write_d  = write_q;
      wdata_d  = wdata_q;
      wstrb_d  = wstrb_q;
      grant_if = 1'b0;
      grant_ls = 1'b0;

      unique case (state_q)
         IDLE: begin
            // Reset gates acceptance so the stall outputs stay truthful during reset.
            if (!reset) begin
               if (bus.if_req_valid && (!bus.ls_req_valid || starve_q == STARVE_MAX))
                  grant_if = 1'b1;
               else if (bus.ls_req_valid)
                  grant_ls = 1'b1;
            end
         end
         ISSUE:   if (!bus.mem_stall) state_d = WAIT;
         WAIT:    if (bus.mem_rsp_valid) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (grant_if) begin
         state_d  = ISSUE;
         owner_d  = OWN_IF;
         addr_d   = bus.if_addr;
         write_d  = 1'b0;
         wdata_d  = '0;
         wstrb_d  = '0;
         starve_d = '0;
      end else if (grant_ls) begin
         state_d  = ISSUE;
         owner_d  = OWN_LS;
         addr_d   = bus.ls_addr;
         write_d  = bus.ls_write;
         wdata_d  = bus.ls_wdata;
         wstrb_d  = bus.ls_wstrb;
         if (!bus.if_req_valid)
            starve_d = '0;
         else if (starve_q != STARVE_MAX)
            starve_d = starve_q + 1'b1;
      end
   end

   // Responses outside WAIT are protocol violations and are dropped here.
   assign rsp_fire = (state_q == WAIT) && bus.mem_rsp_valid && !reset;

   assign bus.if_stall      = bus.if_req_valid && !grant_if;
   assign bus.ls_stall      = bus.ls_req_valid && !grant_ls;
   assign bus.if_rsp_valid  = rsp_fire && (owner_q == OWN_IF);
   assign bus.ls_rsp_valid  = rsp_fire && (owner_q == OWN_LS);
   assign bus.if_rsp_data   = bus.mem_rsp_data;
   assign bus.ls_rsp_data   = bus.mem_rsp_data;

   assign bus.mem_req_valid = (state_q == ISSUE) && !reset;
   assign bus.mem_addr      = addr_q;
   assign bus.mem_write     = write_q;
   assign bus.mem_wdata     = wdata_q;
   assign bus.mem_wstrb     = wstrb_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: the bench plays both requesters and the memory,
// driving inputs 2 time units after each rising edge and sampling 1 unit later.
module tb_mem_port_arbiter;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   mem_port_arbiter #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .STARVE_LIMIT(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus.slave)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      logic exp_if_grant [6];
      exp_if_grant = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

      reset             = 1'b1;
      bus.if_req_valid  = 1'b0;
      bus.if_addr       = '0;
      bus.ls_req_valid  = 1'b0;
      bus.ls_addr       = '0;
      bus.ls_write      = 1'b0;
      bus.ls_wdata      = '0;
      bus.ls_wstrb      = '0;
      bus.mem_stall     = 1'b0;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_data  = '0;

      // Reset state; a request during reset must not be accepted
      repeat (2) next_cycle();
      bus.if_req_valid = 1'b1;
      settle();
      check("rst_mem_req_valid", bus.mem_req_valid, 0);
      check("rst_mem_addr", bus.mem_addr, 0);
      check("rst_if_rsp_valid", bus.if_rsp_valid, 0);
      check("rst_ls_rsp_valid", bus.ls_rsp_valid, 0);
      check("rst_if_stall", bus.if_stall, 1);
      check("rst_starve", dut.starve_q, 0);

      // IF only
      next_cycle();
      reset = 1'b0;
      bus.if_addr = 32'h100;
      settle();
      check("t1_if_stall", bus.if_stall, 0);
      check("t1_idle_mem_req", bus.mem_req_valid, 0);
      next_cycle();
      bus.if_req_valid = 1'b0;
      settle();
      check("t1_mem_req_valid", bus.mem_req_valid, 1);
      check("t1_mem_addr", bus.mem_addr, 32'h100);
      check("t1_mem_write", bus.mem_write, 0);
      check("t1_mem_wstrb", bus.mem_wstrb, 0);
      next_cycle();
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = 32'hDEADBEEF;
      settle();
      check("t1_wait_mem_req", bus.mem_req_valid, 0);
      check("t1_if_rsp_valid", bus.if_rsp_valid, 1);
      check("t1_if_rsp_data", bus.if_rsp_data, 32'hDEADBEEF);
      check("t1_ls_rsp_valid", bus.ls_rsp_valid, 0);
      next_cycle();
      bus.mem_rsp_valid = 1'b0;
      settle();
      check("t1_if_rsp_once", bus.if_rsp_valid, 0);
      check("t1_mem_req_once", bus.mem_req_valid, 0);

      // Simultaneous IF and LS store: LS wins
      bus.if_req_valid = 1'b1;
      bus.if_addr      = 32'h300;
      bus.ls_req_valid = 1'b1;
      bus.ls_addr      = 32'h200;
      bus.ls_write     = 1'b1;
      bus.ls_wdata     = 32'h12345678;
      bus.ls_wstrb     = 4'hF;
      settle();
      check("t2_ls_stall", bus.ls_stall, 0);
      check("t2_if_stall", bus.if_stall, 1);
      next_cycle();
      bus.ls_req_valid = 1'b0;
      settle();
      check("t2_mem_write", bus.mem_write, 1);
      check("t2_mem_addr", bus.mem_addr, 32'h200);
      check("t2_mem_wdata", bus.mem_wdata, 32'h12345678);
      check("t2_mem_wstrb", bus.mem_wstrb, 4'hF);
      check("t2_if_stall_issue", bus.if_stall, 1);
      check("t2_starve_one", dut.starve_q, 1);
      next_cycle();
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = 32'h0;
      settle();
      check("t2_ls_rsp_valid", bus.ls_rsp_valid, 1);
      check("t2_if_rsp_valid", bus.if_rsp_valid, 0);
      next_cycle();
      bus.mem_rsp_valid = 1'b0;
      settle();
      check("t2_if_accept", bus.if_stall, 0);
      next_cycle();
      bus.if_req_valid = 1'b0;
      settle();
      check("t2_if_mem_addr", bus.mem_addr, 32'h300);
      check("t2_if_mem_write", bus.mem_write, 0);
      check("t2_starve_zero", dut.starve_q, 0);
      next_cycle();
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = 32'hCAFE0001;
      settle();
      check("t2_if_rsp", bus.if_rsp_data, 32'hCAFE0001);
      check("t2_if_rsp_valid2", bus.if_rsp_valid, 1);
      next_cycle();
      bus.mem_rsp_valid = 1'b0;

      // Starvation: both held valid, expected grants LS LS LS LS IF LS
      bus.if_req_valid = 1'b1;
      bus.if_addr      = 32'h600;
      bus.ls_req_valid = 1'b1;
      bus.ls_addr      = 32'h700;
      bus.ls_write     = 1'b0;
      bus.ls_wstrb     = '0;
      for (int k = 0; k < 6; k++) begin
         settle();
         check($sformatf("t3_if_stall_%0d", k), bus.if_stall, !exp_if_grant[k]);
         check($sformatf("t3_ls_stall_%0d", k), bus.ls_stall, exp_if_grant[k]);
         next_cycle();
         settle();
         check($sformatf("t3_mem_addr_%0d", k), bus.mem_addr,
               exp_if_grant[k] ? 64'h600 : 64'h700);
         if (k == 4) check("t3_starve_after_if", dut.starve_q, 0);
         next_cycle();
         bus.mem_rsp_valid = 1'b1;
         bus.mem_rsp_data  = 32'h1000 + k;
         settle();
         check($sformatf("t3_both_stall_%0d", k), bus.if_stall && bus.ls_stall, 1);
         check($sformatf("t3_if_rsp_%0d", k), bus.if_rsp_valid, exp_if_grant[k]);
         check($sformatf("t3_ls_rsp_%0d", k), bus.ls_rsp_valid, !exp_if_grant[k]);
         next_cycle();
         bus.mem_rsp_valid = 1'b0;
      end
      bus.if_req_valid = 1'b0;
      bus.ls_req_valid = 1'b0;

      // Memory backpressure during ISSUE with IF waiting
      bus.ls_req_valid = 1'b1;
      bus.ls_addr      = 32'h400;
      bus.ls_write     = 1'b1;
      bus.ls_wdata     = 32'hAABBCCDD;
      bus.ls_wstrb     = 4'h3;
      settle();
      check("t4_ls_accept", bus.ls_stall, 0);
      next_cycle();
      bus.ls_req_valid = 1'b0;
      bus.if_req_valid = 1'b1;
      bus.if_addr      = 32'h800;
      for (int c = 0; c < 4; c++) begin
         bus.mem_stall     = (c < 3);
         bus.mem_rsp_valid = (c == 0);
         settle();
         check($sformatf("t4_mem_req_%0d", c), bus.mem_req_valid, 1);
         check($sformatf("t4_mem_addr_%0d", c), bus.mem_addr, 32'h400);
         check($sformatf("t4_mem_wdata_%0d", c), bus.mem_wdata, 32'hAABBCCDD);
         check($sformatf("t4_if_stall_%0d", c), bus.if_stall, 1);
         if (c == 0) check("t4_stray_rsp_issue", bus.ls_rsp_valid, 0);
         next_cycle();
      end
      bus.mem_stall     = 1'b0;
      bus.mem_rsp_valid = 1'b0;
      settle();
      check("t4_wait_mem_req", bus.mem_req_valid, 0);
      check("t4_wait_if_stall", bus.if_stall, 1);
      next_cycle();
      bus.mem_rsp_valid = 1'b1;
      settle();
      check("t4_ls_rsp", bus.ls_rsp_valid, 1);
      check("t4_if_stall_rsp", bus.if_stall, 1);
      next_cycle();
      bus.mem_rsp_valid = 1'b0;
      settle();
      check("t4_if_accept", bus.if_stall, 0);
      next_cycle();
      bus.if_req_valid = 1'b0;
      next_cycle();
      bus.mem_rsp_valid = 1'b1;
      settle();
      check("t4_if_rsp", bus.if_rsp_valid, 1);
      next_cycle();
      bus.mem_rsp_valid = 1'b0;

      // Reset while waiting on an LS load
      bus.ls_req_valid = 1'b1;
      bus.ls_addr      = 32'h500;
      bus.ls_write     = 1'b0;
      settle();
      check("t5_ls_accept", bus.ls_stall, 0);
      next_cycle();
      bus.ls_req_valid = 1'b0;
      next_cycle();
      reset = 1'b1;
      settle();
      check("t5_rst_ls_rsp", bus.ls_rsp_valid, 0);
      next_cycle();
      reset = 1'b0;
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = 32'h55AA55AA;
      bus.if_req_valid  = 1'b1;
      bus.if_addr       = 32'h900;
      settle();
      check("t5_stray_ls_rsp", bus.ls_rsp_valid, 0);
      check("t5_stray_if_rsp", bus.if_rsp_valid, 0);
      check("t5_idle_accept", bus.if_stall, 0);
      check("t5_mem_addr_cleared", bus.mem_addr, 0);
      next_cycle();
      bus.if_req_valid  = 1'b0;
      bus.mem_rsp_valid = 1'b0;
      settle();
      check("t5_if_mem_addr", bus.mem_addr, 32'h900);

      // Withdrawal: LS asserts during WAIT and drops before IDLE
      next_cycle();
      bus.ls_req_valid = 1'b1;
      bus.ls_addr      = 32'hA00;
      settle();
      check("t6_ls_stall_wait", bus.ls_stall, 1);
      next_cycle();
      bus.ls_req_valid  = 1'b0;
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = 32'h77;
      settle();
      check("t6_ls_stall_drop", bus.ls_stall, 0);
      check("t6_if_rsp", bus.if_rsp_valid, 1);
      next_cycle();
      bus.mem_rsp_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         settle();
         check($sformatf("t6_no_issue_%0d", c), bus.mem_req_valid, 0);
         next_cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port between the instruction-fetch (IF) and load/store (LS) pipeline stages.
- Each requester sees a valid/stall interface, so its upstream hold stage keeps data stable while stalled.
- One transaction is outstanding at a time, sequenced by a 3-state FSM.
- LS has priority; a starvation counter guarantees IF forward progress.

Parameters:
- ADDR_WIDTH, 32, address width for both requesters and the memory port.
- DATA_WIDTH, 32, data width; must be a multiple of 8.
- STARVE_LIMIT, 4, consecutive LS grants allowed while IF is waiting before IF is forced; must be ≥1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- if_req_valid  in  1  IF request present.
- if_addr  in  ADDR_WIDTH  IF read address.
- if_stall  out  1  IF request not accepted this cycle; hold inputs.
- if_rsp_valid  out  1  IF read data valid, one-cycle pulse.
- if_rsp_data  out  DATA_WIDTH  IF read data.
- ls_req_valid  in  1  LS request present.
- ls_addr  in  ADDR_WIDTH  LS address.
- ls_write  in  1  1 = store, 0 = load.
- ls_wdata  in  DATA_WIDTH  store data.
- ls_wstrb  in  DATA_WIDTH/8  store byte enables.
- ls_stall  out  1  LS request not accepted this cycle.
- ls_rsp_valid  out  1  LS completion pulse; load data or store acknowledge.
- ls_rsp_data  out  DATA_WIDTH  load data; don't-care for stores.
- mem_req_valid  out  1  request to memory.
- mem_addr  out  ADDR_WIDTH  latched address.
- mem_write  out  1  latched write flag; 0 for IF.
- mem_wdata  out  DATA_WIDTH  latched store data.
- mem_wstrb  out  DATA_WIDTH/8  latched byte enables; 0 for IF.
- mem_stall  in  1  memory cannot accept the request this cycle.
- mem_rsp_valid  in  1  memory response; exactly one per accepted request, including writes.
- mem_rsp_data  in  DATA_WIDTH  response data.

Behaviour:
- FSM states:
  - IDLE
  - ISSUE: request latched, presented to memory.
  - WAIT: accepted, awaiting response.
- Reset:
  - state = IDLE, starve_cnt = 0, owner = IF, all latched request fields = 0.
  - mem_req_valid = 0, if_rsp_valid = 0, ls_rsp_valid = 0.
  - No request is accepted while reset = 1.
- Acceptance:
  - Requests are accepted only in IDLE with reset = 0.
  - Exactly one requester is accepted per IDLE cycle.
  - x_stall = x_req_valid && !(accepted this cycle). Combinational; 0 whenever x_req_valid = 0.
- Grant rule in IDLE:
  - Only one requester valid → it wins.
  - Both valid → IF wins if starve_cnt == STARVE_LIMIT, else LS wins.
- Acceptance latches addr/write/wdata/wstrb (IF: write = 0, wstrb = 0) and owner; next state = ISSUE.
- starve_cnt, updated on each acceptance:
  - IF granted → 0.
  - LS granted with if_req_valid = 1 → +1, saturating at STARVE_LIMIT.
  - LS granted with if_req_valid = 0 → 0.
  - Counter width is clog2(STARVE_LIMIT+1).
- ISSUE:
  - mem_req_valid = 1; mem_* outputs driven from the latches and stable while mem_stall = 1.
  - mem_stall = 0 → WAIT. mem_stall = 1 → remain in ISSUE.
- WAIT:
  - mem_req_valid = 0.
  - On mem_rsp_valid: the owner's x_rsp_valid = 1 in the same cycle (combinational pass-through), x_rsp_data = mem_rsp_data; next state = IDLE.
  - The non-owner's rsp_valid stays 0.
- mem_rsp_valid in IDLE or ISSUE is a protocol violation. It is ignored: no rsp output is pulsed.
- Minimum cost: 3 cycles per transaction (accept, issue, response with zero memory latency). A new accept can occur in the cycle after the response.
- Reset mid-transaction:
  - Returns to IDLE immediately and drops the in-flight transaction; no rsp pulse is produced.
  - The memory side is reset concurrently.
- Requesters must hold req and fields stable while stalled. Deasserting req_valid while stalled withdraws the request cleanly.

Test Plan:
- IF only: if_addr = 0x100, mem_stall = 0, memory responds 1 cycle after accept with 0xDEADBEEF → if_stall = 0 in the accept cycle; mem_req_valid high for exactly 1 cycle with mem_addr = 0x100, mem_write = 0; if_rsp_valid pulses once with 0xDEADBEEF; ls_rsp_valid stays 0.
- Simultaneous: IF and LS store (addr 0x200, wdata 0x12345678, wstrb 0xF) valid in the same IDLE cycle → LS accepted, if_stall = 1; mem_write = 1; ls_rsp_valid pulse on the ack; IF accepted on the next IDLE cycle.
- Starvation: IF and LS held continuously valid, STARVE_LIMIT = 4 → grant order LS, LS, LS, LS, IF, then LS resumes; starve_cnt returns to 0 after the IF grant.
- Memory backpressure: mem_stall = 1 for 3 cycles during ISSUE → mem_req_valid and mem_addr/mem_wdata stable for 4 cycles; no acceptance of a new request until the response arrives.
- Reset in WAIT: assert reset 1 cycle after memory accepts the LS load → state IDLE, no ls_rsp_valid pulse; a stray mem_rsp_valid after reset produces no rsp outputs.
- Withdrawal: ls_req_valid asserted while in WAIT, then deasserted before IDLE → ls_stall = 1 only while valid; no LS transaction issued.
